alu_request_scheduler: RTL and testbench
========================================

ALU_REQUEST_SCHEDULER -- requirements
Module: alu_request_scheduler

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 2, meaning cycles from ALU issue to result-valid (legal range 1..4).
REQ-002 SHALL have port c_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports reqN_cmd_in, N=1..4, input, [0:3]: requester command (0 = no-op).
REQ-005 SHALL have ports reqN_data_in, N=1..4, input, [0:31]: operand1 in the command cycle, operand2 in the following cycle.
REQ-006 SHALL have ports reqN_busy, N=1..4, output, 1: port has a command in flight.
REQ-007 SHALL have ports prio_alu_in_cmd [0:3], prio_alu_in_op1 [0:31], prio_alu_in_op2 [0:31], output: operation issued to ALU.
REQ-008 SHALL have ports prio_alu_in_req_id [0:1] and prio_alu_in_vld [1], output: issuing port (00 = port 1 .. 11 = port 4) and issue strobe.
REQ-009 SHALL have ports prio_alu_out_req_id [0:1] and prio_alu_out_vld [1], output: result owner and result-valid strobe for the output stage.
REQ-010 SHALL have port local_error_found, output, 1: result in this cycle belongs to an invalid command.

Function
REQ-011 SHALL treat cmd 1 (add), 2 (sub), 5 (shift left), 6 (shift right) as valid; any other nonzero cmd as invalid but still scheduled.
REQ-012 SHALL, per port, capture cmd and operand1 in cycle T when cmd != 0 and the port is not busy, and operand2 in cycle T+1.
REQ-013 SHALL assert reqN_busy from cycle T+1 through the cycle that port's prio_alu_out_vld is asserted, inclusive.
REQ-014 SHALL ignore a nonzero cmd on a busy port (no capture, no state change); the cmd is lost.
REQ-015 SHALL mark a port pending from cycle T+2 until it is granted.
REQ-016 SHALL issue at most one pending port per cycle, chosen round-robin starting at the port after the last granted one.
REQ-017 SHALL start the round-robin pointer at port 1 after reset.
REQ-018 SHALL drive prio_alu_in_vld=1 with cmd, op1, op2 and req_id of the granted port in the grant cycle, registered outputs, earliest cycle T+2.
REQ-019 SHALL drive prio_alu_in_cmd/op1/op2/req_id to zero whenever prio_alu_in_vld=0.
REQ-020 SHALL carry {vld, req_id, invalid-flag} through an ALU_LATENCY-deep shift register, giving prio_alu_out_vld exactly ALU_LATENCY cycles after prio_alu_in_vld.
REQ-021 SHALL drive local_error_found=1 only in a prio_alu_out_vld cycle whose command was invalid; prio_alu_out_req_id=00 when not valid.
REQ-022 SHALL allow a port to present a new command in the cycle after its result cycle; a command in the result cycle itself is ignored.
REQ-023 SHALL advance the round-robin pointer only on a grant; with no pending port, no issue and pointer unchanged.
REQ-024 SHALL keep up to four commands in flight concurrently, one per port, with no loss or reordering within a port.

Reset
REQ-025 SHALL, while reset=1, clear all pending/busy state, capture registers, delay line and pointer at the next edge.
REQ-026 SHALL hold every output at zero while reset=1 and in the first cycle after reset deasserts.
REQ-027 SHALL discard in-flight commands on reset mid-operation; no result strobe for them after reset.
REQ-028 SHALL ignore reqN_cmd_in during any cycle in which reset=1.

Verification
REQ-029 SHALL verify single issue: req1 cmd=1 op1=0x5, op2=0x3 at T,T+1 -> prio_alu_in_vld at T+2 with id 00, cmd 1, op1 5, op2 3; prio_alu_out_vld id 00 at T+4 (ALU_LATENCY=2); req1_busy T+1..T+4.
REQ-030 SHALL verify fairness: all four ports cmd=2 in same cycle T -> issues at T+2..T+5 with ids 00,01,10,11; results at T+4..T+7, one per cycle.
REQ-031 SHALL verify round-robin rotation: after port 2 granted, ports 1 and 3 pending together -> port 3 granted first.
REQ-032 SHALL verify busy drop: req2 cmd=5 at T, second cmd=6 at T+2 -> only cmd 5 issued; req2 accepts cmd at T+5 (result at T+4).
REQ-033 SHALL verify invalid command: req4 cmd=0xF -> issued with id 11, result strobe with local_error_found=1; valid cmds give 0.
REQ-034 SHALL verify reset mid-operation: reset=1 one cycle while ports 1,3 in flight -> no prio_alu_out_vld afterwards, all busy=0, next grant goes to port 1.

Source files
------------

// File: rtl/alu_request_scheduler.sv
// Round-robin scheduler feeding four requester ports into one shared ALU.
// Tracks busy/pending per port and delays result ownership by ALU_LATENCY.
module alu_request_scheduler #(
    parameter int ALU_LATENCY = 2
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic        req1_busy,
    output logic        req2_busy,
    output logic        req3_busy,
    output logic        req4_busy,
    output logic [0:3]  prio_alu_in_cmd,
    output logic [0:31] prio_alu_in_op1,
    output logic [0:31] prio_alu_in_op2,
    output logic [0:1]  prio_alu_in_req_id,
    output logic        prio_alu_in_vld,
    output logic [0:1]  prio_alu_out_req_id,
    output logic        prio_alu_out_vld,
    output logic        local_error_found
);

    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    // Per-port state: busy spans capture to result; wait_op2 is the
    // operand2 cycle; pending means both operands held, not yet granted.
    logic [3:0]  busy;
    logic [3:0]  wait_op2;
    logic [3:0]  pending;
    logic [3:0]  accept;
    logic [3:0]  release_q;
    logic [3:0]  cmd_q [4];
    logic [31:0] op1_q [4];
    logic [31:0] op2_q [4];

    // Round-robin pointer names the highest-priority port.
    logic [1:0]  ptr;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic [1:0]  idx;

    logic        iss_vld;
    logic        iss_inv;
    logic [1:0]  iss_id;
    logic [3:0]  iss_cmd;
    logic [31:0] iss_op1;
    logic [31:0] iss_op2;

    logic        dl_vld [ALU_LATENCY];
    logic        dl_inv [ALU_LATENCY];
    logic [1:0]  dl_id  [ALU_LATENCY];

    logic        res_vld;
    logic        res_inv;
    logic [1:0]  res_id;

    assign res_vld = dl_vld[ALU_LATENCY-1];
    assign res_inv = dl_inv[ALU_LATENCY-1];
    assign res_id  = dl_id[ALU_LATENCY-1];

    function automatic logic cmd_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // Capture and release qualifiers per port.
    always_comb begin
        accept    = '0;
        release_q = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i]    = (cmd_in[i] != 4'd0) && !busy[i];
            release_q[i] = res_vld && (res_id == 2'(i));
        end
    end

    // Round-robin pick; a port in its operand2 cycle already competes
    // so its issue lands two cycles after the command.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 2'd0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!grant_vld && (pending[idx] || wait_op2[idx])) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Per-port capture, busy and pending tracking.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            busy     <= '0;
            wait_op2 <= '0;
            pending  <= '0;
            for (int i = 0; i < 4; i++) begin
                cmd_q[i] <= '0;
                op1_q[i] <= '0;
                op2_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    busy[i]     <= 1'b1;
                    wait_op2[i] <= 1'b1;
                    cmd_q[i]    <= cmd_in[i];
                    op1_q[i]    <= data_in[i];
                end else if (release_q[i]) begin
                    busy[i] <= 1'b0;
                end
                if (wait_op2[i]) begin
                    wait_op2[i] <= 1'b0;
                    op2_q[i]    <= data_in[i];
                    pending[i]  <= !(grant_vld && grant_id == 2'(i));
                end else if (grant_vld && grant_id == 2'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Issue register toward the ALU; pointer moves only on a grant.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            iss_vld <= 1'b0;
            iss_inv <= 1'b0;
            iss_id  <= '0;
            iss_cmd <= '0;
            iss_op1 <= '0;
            iss_op2 <= '0;
            ptr     <= '0;
        end else begin
            iss_vld <= grant_vld;
            if (grant_vld) begin
                iss_inv <= !cmd_valid(cmd_q[grant_id]);
                iss_id  <= grant_id;
                iss_cmd <= cmd_q[grant_id];
                iss_op1 <= op1_q[grant_id];
                iss_op2 <= wait_op2[grant_id] ? data_in[grant_id]
                                              : op2_q[grant_id];
                ptr     <= grant_id + 2'd1;
            end else begin
                iss_inv <= 1'b0;
                iss_id  <= '0;
                iss_cmd <= '0;
                iss_op1 <= '0;
                iss_op2 <= '0;
            end
        end
    end

    // Delay line matching the ALU pipeline depth.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int k = 0; k < ALU_LATENCY; k++) begin
                dl_vld[k] <= 1'b0;
                dl_inv[k] <= 1'b0;
                dl_id[k]  <= '0;
            end
        end else begin
            dl_vld[0] <= iss_vld;
            dl_inv[0] <= iss_vld && iss_inv;
            dl_id[0]  <= iss_id;
            for (int k = 1; k < ALU_LATENCY; k++) begin
                dl_vld[k] <= dl_vld[k-1];
                dl_inv[k] <= dl_inv[k-1];
                dl_id[k]  <= dl_id[k-1];
            end
        end
    end

    // Outputs forced low while reset is held.
    assign req1_busy           = !reset && busy[0];
    assign req2_busy           = !reset && busy[1];
    assign req3_busy           = !reset && busy[2];
    assign req4_busy           = !reset && busy[3];
    assign prio_alu_in_vld     = !reset && iss_vld;
    assign prio_alu_in_cmd     = reset ? 4'd0 : iss_cmd;
    assign prio_alu_in_op1     = reset ? 32'd0 : iss_op1;
    assign prio_alu_in_op2     = reset ? 32'd0 : iss_op2;
    assign prio_alu_in_req_id  = reset ? 2'd0 : iss_id;
    assign prio_alu_out_vld    = !reset && res_vld;
    assign prio_alu_out_req_id = (reset || !res_vld) ? 2'd0 : res_id;
    assign local_error_found   = !reset && res_vld && res_inv;

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Directed bench for alu_request_scheduler (ALU_LATENCY = 2).
// Cycle table for the main flows, hand sequences for rotation and reset.
module tb_alu_request_scheduler;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic        req1_busy, req2_busy, req3_busy, req4_busy;
    logic [0:3]  prio_alu_in_cmd;
    logic [0:31] prio_alu_in_op1;
    logic [0:31] prio_alu_in_op2;
    logic [0:1]  prio_alu_in_req_id;
    logic        prio_alu_in_vld;
    logic [0:1]  prio_alu_out_req_id;
    logic        prio_alu_out_vld;
    logic        local_error_found;

    int total = 0;
    int bad   = 0;

    alu_request_scheduler #(.ALU_LATENCY(2)) dut (
        .c_clk               (c_clk),
        .reset               (reset),
        .req1_cmd_in         (req1_cmd_in),
        .req2_cmd_in         (req2_cmd_in),
        .req3_cmd_in         (req3_cmd_in),
        .req4_cmd_in         (req4_cmd_in),
        .req1_data_in        (req1_data_in),
        .req2_data_in        (req2_data_in),
        .req3_data_in        (req3_data_in),
        .req4_data_in        (req4_data_in),
        .req1_busy           (req1_busy),
        .req2_busy           (req2_busy),
        .req3_busy           (req3_busy),
        .req4_busy           (req4_busy),
        .prio_alu_in_cmd     (prio_alu_in_cmd),
        .prio_alu_in_op1     (prio_alu_in_op1),
        .prio_alu_in_op2     (prio_alu_in_op2),
        .prio_alu_in_req_id  (prio_alu_in_req_id),
        .prio_alu_in_vld     (prio_alu_in_vld),
        .prio_alu_out_req_id (prio_alu_out_req_id),
        .prio_alu_out_vld    (prio_alu_out_vld),
        .local_error_found   (local_error_found)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic        rst;
        logic [15:0] cmd;
        logic [31:0] d [4];
        logic [78:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [78:0] ex(
        input logic [3:0]  busy,
        input logic        ivld,
        input logic [1:0]  iid,
        input logic [3:0]  icmd,
        input logic [31:0] op1,
        input logic [31:0] op2,
        input logic        ovld,
        input logic [1:0]  oid,
        input logic        err
    );
        return {busy, ivld, iid, icmd, op1, op2, ovld, oid, err};
    endfunction

    function automatic logic [78:0] act();
        return {req4_busy, req3_busy, req2_busy, req1_busy,
                prio_alu_in_vld, prio_alu_in_req_id, prio_alu_in_cmd,
                prio_alu_in_op1, prio_alu_in_op2,
                prio_alu_out_vld, prio_alu_out_req_id, local_error_found};
    endfunction

    task automatic add(
        input logic        rst,
        input logic [15:0] cmd,
        input logic [31:0] d1, d2, d3, d4,
        input logic [78:0] e
    );
        vec_t v;
        v.rst  = rst;
        v.cmd  = cmd;
        v.d[0] = d1;
        v.d[1] = d2;
        v.d[2] = d3;
        v.d[3] = d4;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [78:0] a,
                       input logic [78:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
        req1_cmd_in = '0;
        req2_cmd_in = '0;
        req3_cmd_in = '0;
        req4_cmd_in = '0;
    endtask

    localparam logic [78:0] Z = '0;

    initial begin
        reset = 1'b1;
        req1_cmd_in = '0; req2_cmd_in = '0;
        req3_cmd_in = '0; req4_cmd_in = '0;
        req1_data_in = '0; req2_data_in = '0;
        req3_data_in = '0; req4_data_in = '0;

        // reset; command during reset must be ignored
        add(1, 16'h0000, 0, 0, 0, 0, Z);
        add(1, 16'h0001, 9, 0, 0, 0, Z);
        add(0, 16'h0000, 0, 0, 0, 0, Z);
        // single issue on port 1
        add(0, 16'h0001, 5, 0, 0, 0, Z);
        add(0, 16'h0000, 3, 0, 0, 0, ex(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b0001, 1, 0, 1, 5, 3, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0002, 7, 0, 0, 0, ex(4'b0001, 0, 0, 0, 0, 0, 1, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, Z);
        // invalid command on port 4
        add(0, 16'hF000, 0, 0, 0, 32'h11, Z);
        add(0, 16'h0000, 0, 0, 0, 32'h22, ex(4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0,
            ex(4'b1000, 1, 3, 4'hF, 32'h11, 32'h22, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b1000, 0, 0, 0, 0, 0, 1, 3, 1));
        add(0, 16'h0000, 0, 0, 0, 0, Z);
        // fairness: all four ports together
        add(0, 16'h2222, 32'h10, 32'h20, 32'h30, 32'h40, Z);
        add(0, 16'h0000, 1, 2, 3, 4, ex(4'b1111, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0,
            ex(4'b1111, 1, 0, 2, 32'h10, 1, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0,
            ex(4'b1111, 1, 1, 2, 32'h20, 2, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0,
            ex(4'b1111, 1, 2, 2, 32'h30, 3, 1, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0,
            ex(4'b1110, 1, 3, 2, 32'h40, 4, 1, 1, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b1100, 0, 0, 0, 0, 0, 1, 2, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b1000, 0, 0, 0, 0, 0, 1, 3, 0));
        add(0, 16'h0000, 0, 0, 0, 0, Z);
        // busy drop on port 2
        add(0, 16'h0050, 0, 32'hA, 0, 0, Z);
        add(0, 16'h0000, 0, 32'hB, 0, 0, ex(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0060, 0, 32'hC, 0, 0,
            ex(4'b0010, 1, 1, 5, 32'hA, 32'hB, 0, 0, 0));
        add(0, 16'h0000, 0, 32'hD, 0, 0, ex(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b0010, 0, 0, 0, 0, 0, 1, 1, 0));
        add(0, 16'h0060, 0, 32'hE, 0, 0, Z);
        add(0, 16'h0000, 0, 32'hF, 0, 0, ex(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0,
            ex(4'b0010, 1, 1, 6, 32'hE, 32'hF, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 16'h0000, 0, 0, 0, 0, ex(4'b0010, 0, 0, 0, 0, 0, 1, 1, 0));
        add(0, 16'h0000, 0, 0, 0, 0, Z);

        @(posedge c_clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            req1_cmd_in  = tbl[i].cmd[3:0];
            req2_cmd_in  = tbl[i].cmd[7:4];
            req3_cmd_in  = tbl[i].cmd[11:8];
            req4_cmd_in  = tbl[i].cmd[15:12];
            req1_data_in = tbl[i].d[0];
            req2_data_in = tbl[i].d[1];
            req3_data_in = tbl[i].d[2];
            req4_data_in = tbl[i].d[3];
            @(negedge c_clk);
            chk($sformatf("row%0d", i), act(), tbl[i].exp);
            tick();
        end

        // rotation: last grant was port 2, ports 1 and 3 arrive together
        req1_cmd_in = 4'd1; req1_data_in = 32'h1;
        req3_cmd_in = 4'd2; req3_data_in = 32'h3;
        @(negedge c_clk);
        tick();
        req1_data_in = 32'h2;
        req3_data_in = 32'h4;
        @(negedge c_clk);
        chk("rot_busy", 79'({req3_busy, req1_busy}), 79'(2'b11));
        tick();
        @(negedge c_clk);
        chk("rot_first", 79'({prio_alu_in_vld, prio_alu_in_req_id,
            prio_alu_in_cmd, prio_alu_in_op1, prio_alu_in_op2}),
            79'({1'b1, 2'd2, 4'd2, 32'h3, 32'h4}));
        tick();
        @(negedge c_clk);
        chk("rot_second", 79'({prio_alu_in_vld, prio_alu_in_req_id,
            prio_alu_in_cmd, prio_alu_in_op1, prio_alu_in_op2}),
            79'({1'b1, 2'd0, 4'd1, 32'h1, 32'h2}));
        tick();
        @(negedge c_clk);
        chk("rot_res0", 79'({prio_alu_out_vld, prio_alu_out_req_id}),
            79'({1'b1, 2'd2}));
        tick();
        @(negedge c_clk);
        chk("rot_res1", 79'({prio_alu_out_vld, prio_alu_out_req_id,
            local_error_found}), 79'({1'b1, 2'd0, 1'b0}));
        tick();
        @(negedge c_clk);
        chk("rot_idle", act(), Z);
        tick();

        // reset while ports 1 and 3 are in flight
        req1_cmd_in = 4'd1; req1_data_in = 32'h5;
        req3_cmd_in = 4'd1; req3_data_in = 32'h6;
        @(negedge c_clk);
        tick();
        @(negedge c_clk);
        chk("mid_busy", 79'({req3_busy, req1_busy}), 79'(2'b11));
        tick();
        reset = 1'b1;
        @(negedge c_clk);
        chk("mid_rst_out", act(), Z);
        tick();
        reset = 1'b0;
        begin
            int quiet = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge c_clk);
                if (act() !== Z)
                    quiet++;
                tick();
            end
            chk("post_rst_quiet", 79'(quiet), 79'(0));
        end
        req1_cmd_in = 4'd1; req1_data_in = 32'h7;
        req3_cmd_in = 4'd1; req3_data_in = 32'h8;
        @(negedge c_clk);
        tick();
        @(negedge c_clk);
        tick();
        @(negedge c_clk);
        chk("post_rst_grant", 79'({prio_alu_in_vld, prio_alu_in_req_id}),
            79'({1'b1, 2'd0}));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
